// File: rtl/serial_pkg.sv
// Shared types and sizing helpers for the serial shift transmitter.
package serial_pkg;

    typedef enum logic [0:0] {IDLE, SHIFT} ser_state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

    function automatic int unsigned CNT_W(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/bit_down_counter.sv
// Bit counter for the shift stage: loads WIDTH-1, counts down on enable, flags zero.
module bit_down_counter
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic zero_o
);

    localparam int unsigned CntW = CNT_W(WIDTH);
    localparam logic [CntW-1:0] LoadVal = CntW'(WIDTH - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        // A load wins over a decrement so a back-to-back word restarts cleanly.
        if (load_i) begin
            cnt_d = LoadVal;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/serial_shift_tx.sv
// Parallel-to-serial shift stage: loads a word via valid/ready and emits it LSB first.
module serial_shift_tx
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_en_i,
    output logic             ser_out_o,
    output logic             ser_valid_o,
    output logic             done_o
);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             done_q, done_d;

    logic cnt_zero;
    logic cnt_load;
    logic cnt_en;
    logic last_shift;
    logic accept;

    bit_down_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (cnt_load),
        .en_i   (cnt_en),
        .zero_o (cnt_zero)
    );

    // The final bit being consumed frees the stage in the same cycle.
    assign last_shift   = (state_q == SHIFT) && cnt_zero && shift_en_i;
    assign load_ready_o = (state_q == IDLE) || last_shift;
    assign accept       = load_valid_i && load_ready_o;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        done_d   = last_shift;
        cnt_load = accept;
        cnt_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = load_data_i;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en_i) begin
                    cnt_en  = 1'b1;
                    shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                    if (cnt_zero) begin
                        state_d = accept ? SHIFT : IDLE;
                    end
                    if (accept) begin
                        shreg_d = load_data_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            shreg_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            done_q  <= done_d;
        end
    end

    assign ser_valid_o = (state_q == SHIFT);
    assign ser_out_o   = (state_q == SHIFT) ? shreg_q[0] : 1'b0;
    assign done_o      = done_q;

endmodule

// File: doc/serial_shift_tx.md
# serial_shift_tx

Parallel-to-serial shift stage that loads an 8-bit word and emits it one bit per enabled clock, LSB first, by repeated right shift. It sits directly upstream of the single-bit consumers in the logic_elements group and turns a word-wide producer into a 1-bit stream. A valid/ready load handshake and a shift-enable stall let it pace against both sides.

## Interface
Parameters:
- WIDTH, 8, word width in bits; must be at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- load_valid  in  1  producer presents load_data.
- load_ready  out  1  stage can accept a word this cycle.
- load_data  in  WIDTH  word to serialize.
- shift_en  in  1  consumer accepts the current bit; low stalls the stage.
- ser_out  out  1  current serial bit, which is the shift register LSB.
- ser_valid  out  1  ser_out carries a valid bit.
- done  out  1  one-cycle pulse after the last bit of a word is consumed.

## Operation
- Reset values: state is IDLE, the shift register is 0 and the counter is 0. Outputs at reset: ser_out=0, ser_valid=0, done=0, load_ready=1.
- Load: a word is accepted at a clock edge when load_valid and load_ready are both high. On that edge, shreg <= load_data, cnt <= WIDTH-1 and state <= SHIFT.
- IDLE state:
  - load_ready=1 and ser_valid=0.
  - ser_out holds 0.
- SHIFT state:
  - ser_valid=1 and ser_out=shreg[0].
  - On each edge with shift_en=1, the register shifts right with zero fill (shreg <= {1'b0, shreg[WIDTH-1:1]}) and cnt decrements.
  - With shift_en=0, all state holds.
- Last bit: the last bit is presented when cnt==0. If shift_en=1 in that cycle, done pulses on the next cycle.
  - If load_valid is also high in that cycle, the new word loads on the same edge and state stays SHIFT (back-to-back, no bubble).
  - Otherwise state goes to IDLE.
- load_ready = (state==IDLE) or (state==SHIFT and cnt==0 and shift_en). This is combinational.
- load_valid while not ready is ignored. The producer must hold load_data until the handshake completes.
- Changing load_data during SHIFT has no effect.
- Asserting rst_n low at any point, including mid-word, returns immediately to reset values. The partial word is dropped and no done pulse is issued.

## Timing
- Load-to-first-bit latency is 1 cycle: ser_valid rises on the cycle after the handshake edge.
- Without stalls, a word occupies exactly WIDTH cycles of ser_valid=1.
- Each low cycle of shift_en extends the word by exactly one cycle.
- done is a registered output that is high for exactly 1 cycle. It fires on the cycle after the last bit is consumed, and it fires even if a back-to-back load occurred.
- Sustained throughput is one bit per cycle with no idle cycles between back-to-back words.
- ser_out and ser_valid are derived from registers and have no combinational path from inputs.

## Structure
- Package serial_pkg contains:
  - the state typedef `typedef enum logic [0:0] {IDLE, SHIFT} ser_state_t`;
  - the constant DEFAULT_WIDTH = 8;
  - the counter width function CNT_W(WIDTH) = $clog2(WIDTH).
- Sub-module bit_down_counter holds the counter. It is loadable with WIDTH-1, decrements on enable, and has a zero flag output.
- The FSM, shift register and done register stay in the top level.

## Test plan
- Reset then idle: hold rst_n=0 then release. Require load_ready=1, ser_valid=0, ser_out=0 and done=0 for 5 cycles.
- Single word 8'b10110010 with shift_en=1: require ser_out over 8 cycles to be 0,1,0,0,1,1,0,1, then done=1 for one cycle, then IDLE.
- Stall: load 8'hA5 and drop shift_en for 2 cycles after bit 3. Require ser_out to hold bit 3 during the stall, a total of 10 ser_valid cycles, and the bit order unchanged.
- Back-to-back: load 8'hFF, then offer 8'h00 during the last bit. Require 16 contiguous ser_valid cycles (8 ones then 8 zeros) and one done pulse between the words.
- Ignored load: pulse load_valid with 8'h3C mid-word. Require load_ready=0 during the pulse and no corruption of the word in flight.
- Reset mid-operation: assert rst_n after 3 bits of 8'hC3. Require outputs at reset values immediately, no done pulse, and a subsequent load of 8'h01 serializing correctly as 1 followed by seven 0s.
